fp16_normalize: RTL and testbench

Front stage of the half-precision square-root pipeline. Accepts one raw IEEE-754 binary16 operand, classifies it (NaN, ±Inf, ±0, finite), and for finite non-zero values produces an unbiased signed exponent and an 11-bit mantissa with the leading one at bit 10. Subnormals are normalised by a sequential one-bit-per-cycle shift loop. Outputs feed the digit-by-digit iteration stage directly: `n_valid` is the start pulse for that stage.

---
 rtl/fp16_pkg.sv | 29 ++
 rtl/fp16_classify.sv | 54 +++++
 rtl/fp16_normalize.sv | 113 +++++++++++
 tb/tb_fp16_normalize.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp16_pkg
// Brief    : Shared widths, exponent constants and FSM state type for the
//            half-precision square-root front end.
// Revision : 1.0 - initial release
// ============================================================================
package fp16_pkg;

    localparam int EXP_W       = 5;
    localparam int FRAC_W      = 10;
    localparam int MANT_W      = 11;
    localparam int UEXP_W      = 7;

    localparam int EXP_BIAS    = 15;
    localparam int EXP_SUB     = -14;
    localparam int EXP_SPECIAL = 31;

    // Unbiased exponents the output-packing stage uses for special results
    localparam int EXP_INF_NAN = 16;
    localparam int EXP_ZERO    = -15;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } norm_state_t;

endpackage : fp16_pkg
`default_nettype wire

// File: rtl/fp16_classify.sv
`default_nettype none
// ============================================================================
// Module   : fp16_classify
// Brief    : Combinational decode of a binary16 operand into NaN, +Inf, -Inf,
//            zero or finite-positive, with a subnormal qualifier.
// Revision : 1.0 - initial release
// ============================================================================
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [15:0] data_in,
    output logic        is_nan,
    output logic        is_pinf,
    output logic        is_ninf,
    output logic        is_zero,
    output logic        is_fin,
    output logic        is_sub
);

    logic              w_sign;
    logic [EXP_W-1:0]  w_exp;
    logic [FRAC_W-1:0] w_frac;

    assign w_sign = data_in[15];
    assign w_exp  = data_in[14:10];
    assign w_frac = data_in[9:0];

    always_comb begin
        is_nan  = 1'b0;
        is_pinf = 1'b0;
        is_ninf = 1'b0;
        is_zero = 1'b0;
        is_fin  = 1'b0;
        is_sub  = 1'b0;
        if (w_exp == EXP_W'(EXP_SPECIAL)) begin
            if (w_frac != '0)
                is_nan = 1'b1;
            else if (w_sign)
                is_ninf = 1'b1;
            else
                is_pinf = 1'b1;
        end else if (w_exp == '0 && w_frac == '0) begin
            is_zero = 1'b1;
        end else if (w_sign) begin
            // square root of a negative finite operand
            is_nan = 1'b1;
        end else begin
            is_fin = 1'b1;
            is_sub = (w_exp == '0);
        end
    end

endmodule : fp16_classify
`default_nettype wire

// File: rtl/fp16_normalize.sv
`default_nettype none
// ============================================================================
// Module   : fp16_normalize
// Brief    : Classifies a binary16 operand and normalises subnormals with a
//            one-bit-per-cycle shift loop; n_valid starts the iteration stage.
// Revision : 1.0 - initial release
// ============================================================================
module fp16_normalize
    import fp16_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [15:0]              data_in,
    output logic                     ready,
    output logic                     n_valid,
    output logic                     sign_out,
    output logic                     is_nan,
    output logic                     is_pinf,
    output logic                     is_ninf,
    output logic                     is_num,
    output logic [MANT_W-1:0]        mant_out,
    output logic signed [UEXP_W-1:0] exp_out
);

    logic w_is_nan, w_is_pinf, w_is_ninf, w_is_zero, w_is_fin, w_is_sub;

    norm_state_t              r_state;
    logic [FRAC_W-1:0]        r_work_frac;
    logic signed [UEXP_W-1:0] r_work_exp;

    logic [MANT_W-1:0]        w_shift_mant;
    logic signed [UEXP_W-1:0] w_shift_exp;
    logic signed [UEXP_W-1:0] w_norm_exp;

    fp16_classify u_classify (
        .data_in (data_in),
        .is_nan  (w_is_nan),
        .is_pinf (w_is_pinf),
        .is_ninf (w_is_ninf),
        .is_zero (w_is_zero),
        .is_fin  (w_is_fin),
        .is_sub  (w_is_sub)
    );

    // Finishing on the shifted value keeps SHIFT at exactly s cycles
    assign w_shift_mant = {r_work_frac, 1'b0};
    assign w_shift_exp  = r_work_exp - UEXP_W'(1);
    assign w_norm_exp   = UEXP_W'({2'b00, data_in[14:10]}) - UEXP_W'(EXP_BIAS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_work_frac <= '0;
            r_work_exp  <= '0;
            ready       <= 1'b1;
            n_valid     <= 1'b0;
            sign_out    <= 1'b0;
            is_nan      <= 1'b0;
            is_pinf     <= 1'b0;
            is_ninf     <= 1'b0;
            is_num      <= 1'b0;
            mant_out    <= '0;
            exp_out     <= '0;
        end else begin
            n_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (w_is_fin && w_is_sub) begin
                            r_work_frac <= data_in[9:0];
                            r_work_exp  <= UEXP_W'(EXP_SUB);
                            r_state     <= SHIFT;
                            ready       <= 1'b0;
                        end else begin
                            n_valid  <= 1'b1;
                            sign_out <= data_in[15];
                            is_nan   <= w_is_nan;
                            is_pinf  <= w_is_pinf;
                            is_ninf  <= w_is_ninf;
                            is_num   <= w_is_fin;
                            mant_out <= w_is_fin ? {1'b1, data_in[9:0]} : '0;
                            exp_out  <= w_is_fin ? w_norm_exp : '0;
                        end
                    end
                end
                SHIFT: begin
                    if (w_shift_mant[MANT_W-1]) begin
                        n_valid  <= 1'b1;
                        ready    <= 1'b1;
                        r_state  <= IDLE;
                        sign_out <= 1'b0;
                        is_nan   <= 1'b0;
                        is_pinf  <= 1'b0;
                        is_ninf  <= 1'b0;
                        is_num   <= 1'b1;
                        mant_out <= w_shift_mant;
                        exp_out  <= w_shift_exp;
                    end else begin
                        r_work_frac <= w_shift_mant[FRAC_W-1:0];
                        r_work_exp  <= w_shift_exp;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule : fp16_normalize
`default_nettype wire

// File: tb/tb_fp16_normalize.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp16_normalize
// Brief    : Self-checking bench for fp16_normalize against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp16_normalize;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [15:0]       data_in;
    logic              ready;
    logic              n_valid;
    logic              sign_out;
    logic              is_nan;
    logic              is_pinf;
    logic              is_ninf;
    logic              is_num;
    logic [10:0]       mant_out;
    logic signed [6:0] exp_out;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        bit nan, pinf, ninf, num, sign;
        int mant;
        int expo;
        int lat;
    } model_t;

    model_t last_m;

    fp16_normalize dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .data_in  (data_in),
        .ready    (ready),
        .n_valid  (n_valid),
        .sign_out (sign_out),
        .is_nan   (is_nan),
        .is_pinf  (is_pinf),
        .is_ninf  (is_ninf),
        .is_num   (is_num),
        .mant_out (mant_out),
        .exp_out  (exp_out)
    );

    always #5 clk = ~clk;

    // Reference: value-level classification; subnormal f*2^-24 renormalised
    function automatic model_t model(input logic [15:0] x);
        model_t   m;
        int       e, f, msb, sh;
        e = int'(x[14:10]);
        f = int'(x[9:0]);
        m = '{default: 0};
        m.sign = x[15];
        m.lat  = 1;
        if (e == 31 && f != 0)      m.nan = 1;
        else if (e == 31)           begin if (x[15]) m.ninf = 1; else m.pinf = 1; end
        else if (e == 0 && f == 0)  begin end
        else if (x[15])             m.nan = 1;
        else if (e != 0)            begin m.num = 1; m.mant = 1024 + f; m.expo = e - 15; end
        else begin
            msb    = $clog2(f + 1) - 1;
            sh     = 10 - msb;
            m.num  = 1;
            m.mant = f * (2 ** sh);
            m.expo = -14 - sh;
            m.lat  = 1 + sh;
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0d required %0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    task automatic check_outputs(input string tag, input model_t m);
        check({tag, "/nan"},  {31'b0, is_nan},   {31'b0, m.nan});
        check({tag, "/pinf"}, {31'b0, is_pinf},  {31'b0, m.pinf});
        check({tag, "/ninf"}, {31'b0, is_ninf},  {31'b0, m.ninf});
        check({tag, "/num"},  {31'b0, is_num},   {31'b0, m.num});
        check({tag, "/sign"}, {31'b0, sign_out}, {31'b0, m.sign});
        check({tag, "/mant"}, {21'b0, mant_out}, m.mant);
        check({tag, "/exp"},  {{25{exp_out[6]}}, exp_out}, m.expo);
    endtask

    // One operand through the idle handshake, timed to its n_valid pulse
    task automatic run_op(input string tag, input logic [15:0] op);
        model_t m;
        int     cyc, rdy_bad;
        bit     seen;
        m = model(op);
        @(negedge clk);
        check({tag, "/nvalid_low"}, {31'b0, n_valid}, 0);
        check({tag, "/hold_mant"},  {21'b0, mant_out}, last_m.mant);
        check({tag, "/hold_num"},   {31'b0, is_num},   {31'b0, last_m.num});
        check({tag, "/ready_idle"}, {31'b0, ready}, 1);
        in_valid = 1'b1;
        data_in  = op;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in  = 16'($urandom);
        cyc = 0; rdy_bad = 0; seen = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (n_valid === 1'b1) seen = 1;
            else if (ready !== 1'b0) rdy_bad++;
        end
        check({tag, "/latency"},    cyc, m.lat);
        check({tag, "/ready_busy"}, rdy_bad, 0);
        check({tag, "/ready_done"}, {31'b0, ready}, 1);
        check_outputs(tag, m);
        last_m = m;
    endtask

    initial begin
        logic [15:0] ops[12];
        logic [15:0] op;
        model_t      m, zero_m;
        int          nv_cnt, nv_first, sel;
        logic [10:0] cap_mant;
        logic signed [6:0] cap_exp;

        rst = 1'b1; in_valid = 1'b0; data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        zero_m = model(16'h0000);
        check("reset/ready",   {31'b0, ready},   1);
        check("reset/n_valid", {31'b0, n_valid}, 0);
        check_outputs("reset", zero_m);
        last_m = zero_m;

        // Directed operands
        run_op("one",     16'h3C00);
        run_op("minsub",  16'h0001);
        run_op("sub200",  16'h0200);
        run_op("five",    16'h4500);
        run_op("qnan",    16'h7E00);
        run_op("pinf",    16'h7C00);
        run_op("ninf",    16'hFC00);
        run_op("neg2",    16'hC000);
        run_op("negzero", 16'h8000);
        run_op("poszero", 16'h0000);
        run_op("maxsub",  16'h03FF);
        run_op("maxnorm", 16'h7BFF);
        run_op("minnorm", 16'h0400);

        // Back-to-back non-subnormal operands, one per cycle
        ops[0] = 16'h3C00; ops[1] = 16'h7C00; ops[2] = 16'h8000; ops[3] = 16'hC000;
        for (int i = 4; i < 12; i++) begin
            do op = 16'($urandom); while (op[14:10] == 5'd0 && op[9:0] != 10'd0);
            ops[i] = op;
        end
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = ops[0];
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (i < 11) data_in = ops[i+1];
            else        in_valid = 1'b0;
            @(negedge clk);
            check("b2b/n_valid", {31'b0, n_valid}, 1);
            check("b2b/ready",   {31'b0, ready},   1);
            check_outputs("b2b", model(ops[i]));
            last_m = model(ops[i]);
        end

        // in_valid during SHIFT is ignored
        m = model(16'h0001);
        @(negedge clk);
        in_valid = 1'b1; data_in = 16'h0001;
        @(posedge clk);
        #1 in_valid = 1'b0;
        nv_cnt = 0; nv_first = 0; cap_mant = '0; cap_exp = '0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (n_valid === 1'b1) begin
                nv_cnt++;
                if (nv_first == 0) begin nv_first = c; cap_mant = mant_out; cap_exp = exp_out; end
            end
            if (c == 2) begin in_valid = 1'b1; data_in = 16'h3C00; end
            if (c == 3) in_valid = 1'b0;
        end
        check("ignore/count", nv_cnt,   1);
        check("ignore/cycle", nv_first, m.lat);
        check("ignore/mant",  {21'b0, cap_mant}, m.mant);
        check("ignore/exp",   {{25{cap_exp[6]}}, cap_exp}, m.expo);

        // Reset during SHIFT aborts the operand
        @(negedge clk);
        in_valid = 1'b1; data_in = 16'h0001;
        @(posedge clk);
        #1 in_valid = 1'b0;
        nv_cnt = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (n_valid === 1'b1) nv_cnt++;
            if (c == 3) rst = 1'b1;
            if (c == 4) begin
                rst = 1'b0;
                check("abort/ready", {31'b0, ready}, 1);
                check_outputs("abort", zero_m);
            end
        end
        check("abort/no_nvalid", nv_cnt, 0);
        last_m = zero_m;

        // rst and in_valid together: operand dropped
        run_op("pre_rst", 16'h3C00);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; data_in = 16'h7C00;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check("rstwin/ready",   {31'b0, ready},   1);
        check("rstwin/n_valid", {31'b0, n_valid}, 0);
        check_outputs("rstwin", zero_m);
        @(negedge clk);
        check("rstwin/n_valid2", {31'b0, n_valid}, 0);
        last_m = zero_m;

        // Randomised operands weighted towards each class
        for (int i = 0; i < 150; i++) begin
            sel = int'($urandom_range(0, 5));
            op  = 16'($urandom);
            case (sel)
                0: begin op[15:10] = 6'd0; if (op[9:0] == 10'd0) op[0] = 1'b1; end
                1: begin op[15] = 1'b0; if (op[14:10] == 5'd0 || op[14:10] == 5'd31) op[14:10] = 5'd15; end
                2: op[14:10] = 5'd31;
                3: op[14:0] = 15'd0;
                4: begin op[15] = 1'b1; if (op[14:10] == 5'd31) op[14:10] = 5'd3; end
                default: ;
            endcase
            run_op("rand", op);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_fp16_normalize
`default_nettype wire
